// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: streams pixels and weights one MAC per cycle and
// stores one saturated, optionally ReLU-clamped result per output neuron.
module nn_layer_engine #(
  parameter int N_INPUTS  = 784,
  parameter int N_OUTPUTS = 10,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int RES_W     = 17,
  parameter int PIX_AW    = 11,
  parameter int WGT_AW    = 14,
  parameter int OUT_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calc,
  input  logic              relu_en,
  output logic [PIX_AW-1:0] pixel_addr,
  input  logic [DATA_W-1:0] pixel_q,
  output logic [WGT_AW-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_q,
  input  logic [OUT_AW-1:0] result_addr,
  output logic [RES_W-1:0]  result_data,
  output logic              busy,
  output logic              done_calc
);

  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic [OUT_AW-1:0] O_LAST   = OUT_AW'(N_OUTPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  if (N_OUTPUTS * N_INPUTS > (1 << WGT_AW)) begin : g_wgt_aw_chk
    $error("nn_layer_engine: weight memory does not fit WGT_AW");
  end
  if (N_INPUTS > (1 << PIX_AW)) begin : g_pix_aw_chk
    $error("nn_layer_engine: pixel memory does not fit PIX_AW");
  end
  if (N_OUTPUTS > (1 << OUT_AW)) begin : g_out_aw_chk
    $error("nn_layer_engine: result bank does not fit OUT_AW");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MAC   = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      accept_q, accept_d;
  logic                      relu_q, relu_d;
  logic [OUT_AW-1:0]         o_q, o_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PIX_AW-1:0]         pix_addr_q, pix_addr_d;
  logic [WGT_AW-1:0]         wgt_addr_q, wgt_addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]          bank_q [N_OUTPUTS];
  logic [RES_W-1:0]          bank_d [N_OUTPUTS];

  logic signed [PROD_W-1:0]  w_ext_s, p_ext_s, prod_s;
  logic signed [ACC_W-1:0]   prod_acc_s;
  logic [RES_W-1:0]          store_val_s;

  // Both operands extended to the full product width so the multiply is exact
  assign w_ext_s    = {{(PROD_W-DATA_W){weight_q[DATA_W-1]}}, weight_q};
  assign p_ext_s    = {{(PROD_W-DATA_W){1'b0}}, pixel_q};
  assign prod_s     = w_ext_s * p_ext_s;
  assign prod_acc_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

  // Saturate the accumulator to the result range, then apply the latched ReLU mode
  always_comb begin
    store_val_s = acc_q[RES_W-1:0];
    if (acc_q > SAT_MAX) begin
      store_val_s = SAT_MAX[RES_W-1:0];
    end else if (acc_q < SAT_MIN) begin
      store_val_s = SAT_MIN[RES_W-1:0];
    end else begin
      store_val_s = acc_q[RES_W-1:0];
    end
    if (relu_q && store_val_s[RES_W-1]) begin
      store_val_s = {RES_W{1'b0}};
    end else begin
      store_val_s = store_val_s;
    end
  end

  // Next-state logic for the layer sequencer and its registered outputs
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    relu_d     = relu_q;
    o_d        = o_q;
    cnt_d      = cnt_q;
    pix_addr_d = pix_addr_q;
    wgt_addr_d = wgt_addr_q;
    acc_d      = acc_q;
    bank_d     = bank_q;
    case (state_q)
      S_IDLE: begin
        if (accept_q) begin
          state_d    = S_LOAD;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          relu_d     = relu_en;
          o_d        = {OUT_AW{1'b0}};
          acc_d      = {ACC_W{1'b0}};
          pix_addr_d = {PIX_AW{1'b0}};
          wgt_addr_d = {WGT_AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_MAC;
        cnt_d   = {CNT_W{1'b0}};
        acc_d   = {ACC_W{1'b0}};
        if (pix_addr_q < PIX_LAST) begin
          pix_addr_d = pix_addr_q + PIX_AW'(1'b1);
          wgt_addr_d = wgt_addr_q + WGT_AW'(1'b1);
        end else begin
          pix_addr_d = pix_addr_q;
        end
      end
      S_MAC: begin
        // Memory data lags the issued address by one cycle, so the last address is held once
        acc_d = acc_q + prod_acc_s;
        cnt_d = cnt_q + CNT_W'(1'b1);
        if (pix_addr_q < PIX_LAST) begin
          pix_addr_d = pix_addr_q + PIX_AW'(1'b1);
          wgt_addr_d = wgt_addr_q + WGT_AW'(1'b1);
        end else begin
          pix_addr_d = pix_addr_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_STORE;
        end else begin
          state_d = S_MAC;
        end
      end
      S_STORE: begin
        bank_d[o_q] = store_val_s;
        if (o_q == O_LAST) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pix_addr_d = {PIX_AW{1'b0}};
          wgt_addr_d = {WGT_AW{1'b0}};
        end else begin
          state_d    = S_LOAD;
          o_d        = o_q + OUT_AW'(1'b1);
          acc_d      = {ACC_W{1'b0}};
          pix_addr_d = {PIX_AW{1'b0}};
          wgt_addr_d = wgt_addr_q + WGT_AW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // A start request is only captured when the engine will be idle, so requests during a run are dropped
    accept_d = start_calc && (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      accept_q   <= 1'b0;
      relu_q     <= 1'b0;
      o_q        <= {OUT_AW{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      pix_addr_q <= {PIX_AW{1'b0}};
      wgt_addr_q <= {WGT_AW{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      for (int i = 0; i < N_OUTPUTS; i++) begin
        bank_q[i] <= {RES_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      accept_q   <= accept_d;
      relu_q     <= relu_d;
      o_q        <= o_d;
      cnt_q      <= cnt_d;
      pix_addr_q <= pix_addr_d;
      wgt_addr_q <= wgt_addr_d;
      acc_q      <= acc_d;
      for (int i = 0; i < N_OUTPUTS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Combinational bank read; indices past the last neuron read as zero
  always_comb begin
    if (int'(result_addr) < N_OUTPUTS) begin
      result_data = bank_q[result_addr];
    end else begin
      result_data = {RES_W{1'b0}};
    end
  end

  assign pixel_addr  = pix_addr_q;
  assign weight_addr = wgt_addr_q;
  assign busy        = busy_q;
  assign done_calc   = done_q;

endmodule
